// File: rtl/frame_fetch_engine_if.sv
// Signal bundle between the framebuffer fetch engine and the DDR2 FIFOs,
// the pixel FIFO and the display timing logic.
interface frame_fetch_engine_if;
  logic [31:0]  frame_base;
  logic         mirror_x;
  logic         af_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic         rdf_rd_en;
  logic         pf_wr_en;
  logic [127:0] pf_din;
  logic         pix_pop;
  logic         out_enable;
  logic [31:0]  cur_frame;
  logic         underflow;

  modport master (
    input  frame_base, mirror_x, af_full, rdf_valid, rdf_dout, pix_pop,
    output af_wr_en, af_addr_din, rdf_rd_en, pf_wr_en, pf_din,
           out_enable, cur_frame, underflow
  );

  modport slave (
    output frame_base, mirror_x, af_full, rdf_valid, rdf_dout, pix_pop,
    input  af_wr_en, af_addr_din, rdf_rd_en, pf_wr_en, pf_din,
           out_enable, cur_frame, underflow
  );
endinterface

// File: rtl/frame_fetch_engine.sv
// DDR2 framebuffer read engine: raster walk, credit-limited command issue,
// frame base swap at frame end, optional horizontal mirroring of returned beats.
module frame_fetch_engine #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned PIX_PER_REQ = 8,
  parameter int unsigned FIFO_PIX    = 8192,
  parameter int unsigned HIGH_WATER  = 8000,
  parameter int unsigned PRIME_PIX   = 4096,
  parameter int unsigned CNT_W       = 14
) (
  input  logic                  cpu_clk_g,
  input  logic                  rst,
  frame_fetch_engine_if.master  bus
);

  localparam logic [6:0]  XB_LAST  = 7'(H_ACTIVE / PIX_PER_REQ - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
  localparam int unsigned MQ_DEPTH = FIFO_PIX / PIX_PER_REQ;
  localparam int unsigned MQ_AW    = $clog2(MQ_DEPTH);

  typedef enum logic [1:0] {S_PRIME, S_RUN, S_HOLD} state_e;
  typedef enum logic [1:0] {H_EMPTY, H_WAIT, H_READY} hold_e;

  state_e             state_q, state_d;
  logic [6:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [31:0]        cur_frame_q, cur_frame_d;
  logic               mirror_q, mirror_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               out_en_q, out_en_d;
  logic               underflow_q, underflow_d;
  logic [MQ_AW-1:0]   mq_wp_q, mq_wp_d, mq_rp_q, mq_rp_d;
  logic               beat_q, beat_d;
  hold_e              hold_st_q, hold_st_d;
  logic [127:0]       hold_q, hold_d;
  logic               mq_mem [MQ_DEPTH];

  logic [31:0]  occ_w;
  logic         issue, accept, pop_ok, line_end, frame_end, beat_mir;
  logic [6:0]   xb;
  logic [127:0] rev;

  assign occ_w     = 32'(occ_q);
  assign issue     = !rst && (state_q != S_HOLD) &&
                     (occ_w + PIX_PER_REQ <= FIFO_PIX) && (occ_w < HIGH_WATER);
  assign accept    = issue && !bus.af_full;
  assign pop_ok    = bus.pix_pop && (state_q != S_PRIME);
  assign line_end  = (x_q == XB_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);
  assign xb        = mirror_q ? (XB_LAST - x_q) : x_q;

  assign bus.af_wr_en    = issue;
  assign bus.af_addr_din = {6'd0, cur_frame_q[27:22], y_q, xb, 2'd0};
  assign bus.rdf_rd_en   = 1'b1;
  assign bus.out_enable  = out_en_q;
  assign bus.cur_frame   = cur_frame_q;
  assign bus.underflow   = underflow_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PRIME: if (occ_w >= PRIME_PIX)  state_d = S_RUN;
      S_RUN:   if (occ_w >= HIGH_WATER) state_d = S_HOLD;
      S_HOLD:  if (occ_w <  HIGH_WATER) state_d = S_RUN;
      default: state_d = S_PRIME;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    cur_frame_d = cur_frame_q;
    mirror_d    = mirror_q;
    if (accept) begin
      if (line_end) begin
        x_d      = '0;
        mirror_d = bus.mirror_x;
        if (frame_end) begin
          y_d         = '0;
          cur_frame_d = bus.frame_base;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 7'd1;
      end
    end
    occ_d = CNT_W'(occ_w + (accept ? PIX_PER_REQ : 32'd0)
                   - ((pop_ok && occ_q != '0) ? 32'd1 : 32'd0));
    underflow_d = underflow_q | (pop_ok && occ_q == '0);
    out_en_d    = out_en_q | (state_q == S_RUN);
  end

  // Per-command mirror bits, in return order; depth equals the credit limit.
  assign mq_wp_d  = accept ? mq_wp_q + MQ_AW'(1) : mq_wp_q;
  assign mq_rp_d  = (bus.rdf_valid && beat_q) ? mq_rp_q + MQ_AW'(1) : mq_rp_q;
  assign beat_d   = beat_q ^ bus.rdf_valid;
  assign beat_mir = mq_mem[mq_rp_q];
  assign rev      = {bus.rdf_dout[31:0], bus.rdf_dout[63:32],
                     bus.rdf_dout[95:64], bus.rdf_dout[127:96]};

  // Mirrored beat 0 waits in hold until beat 1 has been written; a ready hold
  // is always drained first, so a plain beat arriving then takes its place.
  always_comb begin
    bus.pf_wr_en = 1'b0;
    bus.pf_din   = bus.rdf_dout;
    hold_d       = hold_q;
    hold_st_d    = hold_st_q;
    if (hold_st_q == H_READY) begin
      bus.pf_wr_en = 1'b1;
      bus.pf_din   = hold_q;
      hold_st_d    = H_EMPTY;
    end
    if (bus.rdf_valid) begin
      if (!beat_mir) begin
        if (hold_st_q == H_READY) begin
          hold_d    = bus.rdf_dout;
          hold_st_d = H_READY;
        end else begin
          bus.pf_wr_en = 1'b1;
          bus.pf_din   = bus.rdf_dout;
        end
      end else if (!beat_q) begin
        hold_d    = rev;
        hold_st_d = H_WAIT;
      end else begin
        bus.pf_wr_en = 1'b1;
        bus.pf_din   = rev;
        hold_st_d    = H_READY;
      end
    end
  end

  always_ff @(posedge cpu_clk_g) begin
    if (accept) mq_mem[mq_wp_q] <= mirror_q;
  end

  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      state_q     <= S_PRIME;
      x_q         <= '0;
      y_q         <= '0;
      cur_frame_q <= 32'h1040_0000;
      mirror_q    <= bus.mirror_x;
      occ_q       <= '0;
      out_en_q    <= 1'b0;
      underflow_q <= 1'b0;
      mq_wp_q     <= '0;
      mq_rp_q     <= '0;
      beat_q      <= 1'b0;
      hold_st_q   <= H_EMPTY;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cur_frame_q <= cur_frame_d;
      mirror_q    <= mirror_d;
      occ_q       <= occ_d;
      out_en_q    <= out_en_d;
      underflow_q <= underflow_d;
      mq_wp_q     <= mq_wp_d;
      mq_rp_q     <= mq_rp_d;
      beat_q      <= beat_d;
      hold_st_q   <= hold_st_d;
      hold_q      <= hold_d;
    end
  end

endmodule
